mem_access_unit: RTL and testbench

- Initiator side of the CPU data-memory interface. Sits between the MEM pipeline stage and the word-only data memory.
- Accepts byte, halfword and word load/store requests and issues word-wide reads and writes to memory, using memory ports ctrl_r, ctrl_w, addr, wdata and rdata.
- Sub-word stores are done as read-modify-write. Loads are extracted and sign- or zero-extended.
- Misaligned requests are reported as errors and never reach memory.

---
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator: sub-word loads/stores over a word-only memory port.
// Sub-word stores are read-modify-write; misaligned or reserved-size requests respond with an error.
module mem_access_unit #(
  parameter int BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic        dm_ctrl_r,
  output logic        dm_ctrl_w,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  // Flipping the lane index turns little-endian lane numbering into big-endian.
  localparam logic [1:0] LANE_FLIP = (BIG_ENDIAN != 0) ? 2'b11 : 2'b00;

  state_t      r_state, w_next;
  logic        r_we, r_uns;
  logic [1:0]  r_size, r_lane;
  logic [15:0] r_wdata;
  logic [31:0] r_dm_addr, r_dm_wdata, r_resp_rdata;
  logic        r_resp_err;
  logic        w_accept, w_err;

  function automatic logic [4:0] f_shift(input logic [1:0] size, input logic [1:0] lane);
    if (size == 2'b00) return {lane ^ LANE_FLIP, 3'b000};
    return {lane[1] ^ LANE_FLIP[1], 4'b0000};
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
    logic [31:0] w_sh;
    w_sh = word >> f_shift(size, lane);
    if (size == 2'b10) return word;
    if (size == 2'b00) return uns ? {24'b0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
    return uns ? {16'b0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [15:0] wdata);
    logic [31:0] w_mask, w_data;
    w_mask = ((size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << f_shift(size, lane);
    w_data = ((size == 2'b00) ? {24'b0, wdata[7:0]} : {16'b0, wdata}) << f_shift(size, lane);
    return (word & ~w_mask) | w_data;
  endfunction

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_err    = (req_size == 2'b11) || ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_err)                              w_next = S_RESP;
        else if (req_we && req_size == 2'b10)   w_next = S_WR;
        else                                    w_next = S_RD;
      end
      S_RD:   w_next = r_we ? S_WR : S_RESP;
      S_WR:   w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    dm_ctrl_r  = (r_state == S_RD);
    dm_ctrl_w  = (r_state == S_WR);
    resp_valid = (r_state == S_RESP);
  end

  // The read word is consumed on the RD edge: extended for loads, merged for sub-word stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'b00;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      r_dm_addr    <= 32'h0;
      r_dm_wdata   <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_we      <= req_we;
          r_uns     <= req_unsigned;
          r_size    <= req_size;
          r_lane    <= req_addr[1:0];
          r_wdata   <= req_wdata[15:0];
          r_dm_addr <= {req_addr[31:2], 2'b00};
          if (w_err) begin
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'h0;
          end else if (req_we && req_size == 2'b10) begin
            r_dm_wdata <= req_wdata;
          end
        end
        S_RD: begin
          if (r_we) begin
            r_dm_wdata <= f_merge(dm_rdata, r_size, r_lane, r_wdata);
          end else begin
            r_resp_rdata <= f_extract(dm_rdata, r_size, r_lane, r_uns);
            r_resp_err   <= 1'b0;
          end
        end
        S_WR: begin
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign dm_addr    = r_dm_addr;
  assign dm_wdata   = r_dm_wdata;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts each
// response at issue time; a monitor pops and compares whenever resp_valid is seen.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ctrl_r, dm_ctrl_w;

  always #5 clk = ~clk;

  mem_access_unit #(.BIG_ENDIAN(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_ctrl_r(dm_ctrl_r),
    .dm_ctrl_w(dm_ctrl_w), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  // Word-only memory: combinational read, write on rising edge.
  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (pl_en)          mem[pl_idx] <= pl_data;
    else if (dm_ctrl_w) mem[dm_addr[7:2]] <= dm_wdata;
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nr;
    int          nw;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [0:63];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory seen as four bytes per word, byte 0 most significant.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
    return 8'((w >> (8 * (3 - k))) & 32'hFF);
  endfunction

  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int a, idx;
    int unsigned v;
    logic [7:0] b [4];
    a   = int'(addr[1:0]);
    idx = int'(addr[7:2]);
    e.err   = (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && a != 0);
    e.rdata = 0;
    e.waddr = {addr[31:2], 2'b00};
    e.wdata = 0;
    e.acc   = 0;
    if (e.err) begin
      e.lat = 0; e.nr = 0; e.nw = 0;
      return e;
    end
    for (int k = 0; k < 4; k++) b[k] = get_byte(ref_mem[idx], k);
    if (!we) begin
      e.lat = 1; e.nr = 1; e.nw = 0;
      if (size == 0) begin
        v = b[a];
        if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (size == 1) begin
        v = b[a] * 256 + b[a + 1];
        if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
        v = ref_mem[idx];
      end
      e.rdata = v;
    end else begin
      if (size == 0) begin
        b[a] = wdata[7:0];
        e.lat = 2; e.nr = 1; e.nw = 1;
      end else if (size == 1) begin
        b[a] = wdata[15:8]; b[a + 1] = wdata[7:0];
        e.lat = 2; e.nr = 1; e.nw = 1;
      end else begin
        b[0] = wdata[31:24]; b[1] = wdata[23:16]; b[2] = wdata[15:8]; b[3] = wdata[7:0];
        e.lat = 1; e.nr = 0; e.nw = 1;
      end
      e.wdata = {b[0], b[1], b[2], b[3]};
      ref_mem[idx] = e.wdata;
    end
    return e;
  endfunction

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    exp_t e;
    int   waited;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    waited = 0;
    while (!req_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        n_cmp++; n_fail++;
        $display("FAIL ready_timeout: req_ready still 0 after %0d cycles, expected 1", waited);
        req_valid = 1'b0;
        return;
      end
    end
    e = model(we, size, uns, addr, wdata);
    e.acc = edge_cnt + 1;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  // Monitor: reset values while rst, memory-control usage per transaction, responses in order.
  int nr_seen = 0, nw_seen = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        nr_seen = 0; nw_seen = 0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_dm_addr", dm_addr, 32'd0);
        check("rst_dm_ctrl_r", 32'(dm_ctrl_r), 32'd0);
        check("rst_dm_ctrl_w", 32'(dm_ctrl_w), 32'd0);
        check("rst_dm_wdata", dm_wdata, 32'd0);
        continue;
      end
      if (dm_ctrl_r) nr_seen++;
      if (dm_ctrl_w) begin
        nw_seen++;
        if (sb_q.size() == 0) begin
          check("write_without_request", 32'(dm_ctrl_w), 32'd0);
        end else begin
          check("dm_addr_on_write", dm_addr, sb_q[0].waddr);
          check("dm_wdata", dm_wdata, sb_q[0].wdata);
        end
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_err", 32'(resp_err), 32'(e.err));
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_latency", 32'(edge_cnt - e.acc), 32'(e.lat));
          check("ctrl_r_cycles", 32'(nr_seen), 32'(e.nr));
          check("ctrl_w_cycles", 32'(nw_seen), 32'(e.nw));
        end
        nr_seen = 0; nw_seen = 0;
      end
    end
  end

  initial begin
    logic [31:0] saved;
    logic [31:0] a;
    int          waited;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    pl_idx = 6'd0; pl_data = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      pl_en = 1'b1; pl_idx = 6'(i);
      pl_data = (i == 4) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = pl_data;
      @(negedge clk);
    end
    pl_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed loads from word 0x10
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0);
    // Sub-word stores, word store, read-backs
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_56CC, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    // Errors
    issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

    // Reset during the WR cycle of SB 0x12
    saved = ref_mem[4];
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0077, 1'b0);
    @(negedge clk);
    check("abort_in_wr", 32'(dm_ctrl_w), 32'd1);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("abort_ctrl_w_drop", 32'(dm_ctrl_w), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[4] = saved;
    @(negedge clk);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a = {24'h0, 8'($urandom_range(0, 255))};
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Continuous req_valid with alternating LW/SW
    for (int i = 0; i < 24; i++) begin
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      issue(1'(i % 2), 2'b10, 1'b0, a, $urandom, 1'b1);
    end
    req_valid = 1'b0;

    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("outstanding_responses", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) check("memory_contents", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
